// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard detection and forwarding for a 5-stage MIPS-style
// pipeline, extended with a multi-cycle multiply/divide busy tracker, a sticky
// protocol-error flag and a saturating stall-cycle performance counter.
// Stall, flush and forward outputs are purely combinational; only the md
// counter, the error flag and the stall counter hold state.
// There is no valid/ready handshake on this block: every input is a level
// qualified by the current pipeline contents and is sampled every cycle.
module hazard_unit_mc #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int MD_LATENCY    = 4,
    parameter int PERF_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RF_ADDR_WIDTH-1:0] RsD,
    input  logic [RF_ADDR_WIDTH-1:0] RtD,
    input  logic [RF_ADDR_WIDTH-1:0] RsE,
    input  logic [RF_ADDR_WIDTH-1:0] RtE,
    input  logic [RF_ADDR_WIDTH-1:0] WriteRegE,
    input  logic [RF_ADDR_WIDTH-1:0] WriteRegM,
    input  logic [RF_ADDR_WIDTH-1:0] WriteRegW,
    input  logic                     RegWriteE,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic                     MemtoRegE,
    input  logic                     MemtoRegM,
    input  logic                     BranchD,
    input  logic                     JrD,
    input  logic                     MdStartD,
    input  logic                     MdUseD,
    input  logic                     MdStartE,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     FlushE,
    output logic                     ForwardAD,
    output logic                     ForwardBD,
    output logic [1:0]               ForwardAE,
    output logic [1:0]               ForwardBE,
    output logic                     MdBusy,
    output logic                     MdErr,
    output logic [PERF_WIDTH-1:0]    StallCount
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY);

    // Forward-select encodings for the Execute-stage ALU operand muxes.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    logic [3:0]            md_cnt;
    logic                  md_err;
    logic [PERF_WIDTH-1:0] stall_count;

    // Register-match terms. Register 0 is hardwired to zero, so a match on
    // it is never a real dependency and is masked everywhere.
    logic rs_d_e, rt_d_e, rs_d_m, rt_d_m;
    logic rs_d_lw, rt_d_lw;
    logic lwstall, branchstall, jrstall, mdstall, stall;

    assign rs_d_e  = (RsD != '0) && (RsD == WriteRegE);
    assign rt_d_e  = (RtD != '0) && (RtD == WriteRegE);
    assign rs_d_m  = (RsD != '0) && (RsD == WriteRegM);
    assign rt_d_m  = (RtD != '0) && (RtD == WriteRegM);
    assign rs_d_lw = (RtE != '0) && (RsD == RtE);
    assign rt_d_lw = (RtE != '0) && (RtD == RtE);

    assign MdBusy = (md_cnt != 4'd0);

    // Stall sources: load-use, branch/jr operands not yet available in time
    // for the Decode comparator, and mult/div result or unit not ready.
    always_comb begin
        lwstall     = MemtoRegE && (rs_d_lw || rt_d_lw);
        branchstall = BranchD && ((RegWriteE && (rs_d_e || rt_d_e)) ||
                                  (MemtoRegM && (rs_d_m || rt_d_m)));
        jrstall     = JrD && ((RegWriteE && rs_d_e) || (MemtoRegM && rs_d_m));
        mdstall     = (MdStartD || MdUseD) && (MdBusy || MdStartE);
        stall       = lwstall || branchstall || jrstall || mdstall;
    end

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    // Decode comparator forwarding from ALUOutM, one per source field.
    assign ForwardAD = RegWriteM && rs_d_m;
    assign ForwardBD = RegWriteM && rt_d_m;

    // Execute operand forwarding; the Memory stage holds the younger value
    // so it wins over Writeback when both match.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (RegWriteM && (RsE != '0) && (RsE == WriteRegM))
            ForwardAE = FWD_MEM;
        else if (RegWriteW && (RsE != '0) && (RsE == WriteRegW))
            ForwardAE = FWD_WB;
        if (RegWriteM && (RtE != '0) && (RtE == WriteRegM))
            ForwardBE = FWD_MEM;
        else if (RegWriteW && (RtE != '0) && (RtE == WriteRegW))
            ForwardBE = FWD_WB;
    end

    // Mult/div busy counter: load on an accepted start, otherwise count
    // down; a start while busy is dropped and only raises the error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt <= 4'd0;
            md_err <= 1'b0;
        end else begin
            if (MdStartE && (md_cnt == 4'd0))
                md_cnt <= MD_LOAD;
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
            if (MdStartE && (md_cnt != 4'd0))
                md_err <= 1'b1;
        end
    end

    // Stalled-cycle counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + PERF_WIDTH'(1);
    end

    assign MdErr      = md_err;
    assign StallCount = stall_count;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed scenarios plus randomized traffic for
// hazard_unit_mc, compared against a cycle-level behavioural model. Two
// instances share all inputs: one with a 16-bit stall counter and one with a
// 4-bit counter so that saturation is exercised continuously.
module tb_hazard_unit_mc;

    localparam int AW  = 5;
    localparam int LAT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT signals ----------------
    logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic BranchD, JrD, MdStartD, MdUseD, MdStartE;
    logic StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy, MdErr;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;
    logic StallF_s, StallD_s, FlushE_s, ForwardAD_s, ForwardBD_s, MdBusy_s, MdErr_s;
    logic [1:0]  ForwardAE_s, ForwardBE_s;
    logic [3:0]  StallCount_s;

    hazard_unit_mc #(.RF_ADDR_WIDTH(AW), .MD_LATENCY(LAT), .PERF_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .JrD(JrD), .MdStartD(MdStartD), .MdUseD(MdUseD),
        .MdStartE(MdStartE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .MdErr(MdErr), .StallCount(StallCount)
    );

    hazard_unit_mc #(.RF_ADDR_WIDTH(AW), .MD_LATENCY(LAT), .PERF_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .JrD(JrD), .MdStartD(MdStartD), .MdUseD(MdUseD),
        .MdStartE(MdStartE),
        .StallF(StallF_s), .StallD(StallD_s), .FlushE(FlushE_s),
        .ForwardAD(ForwardAD_s), .ForwardBD(ForwardBD_s),
        .ForwardAE(ForwardAE_s), .ForwardBE(ForwardBE_s),
        .MdBusy(MdBusy_s), .MdErr(MdErr_s), .StallCount(StallCount_s)
    );

    // ---------------- scoreboard / reference model ----------------
    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];   // expected stall counts (16-bit, then 4-bit)

    int cyc;          // clock edges since the model started
    int busy_until;   // unit is busy while cyc < busy_until
    bit err;
    int cnt16, cnt4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [AW-1:0] r);
        if (RegWriteM && hit(r, WriteRegM)) return 2'd2;
        if (RegWriteW && hit(r, WriteRegW)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit model_stall();
        bit busy, lw, br, jr, md;
        busy = (cyc < busy_until);
        lw = MemtoRegE && (hit(RsD, RtE) || hit(RtD, RtE));
        br = BranchD && ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                         (MemtoRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
        jr = JrD && ((RegWriteE && hit(RsD, WriteRegE)) || (MemtoRegM && hit(RsD, WriteRegM)));
        md = (MdStartD || MdUseD) && (busy || MdStartE);
        return lw || br || jr || md;
    endfunction

    task automatic model_reset();
        cyc = 0; busy_until = 0; err = 0; cnt16 = 0; cnt4 = 0;
        exp_q.delete();
        exp_q.push_back(32'(cnt16));
        exp_q.push_back(32'(cnt4));
    endtask

    // Compare every output against the model in the middle of the cycle.
    task automatic check_now();
        bit s, busy;
        logic [31:0] e16, e4;
        @(negedge clk);
        s    = model_stall();
        busy = (cyc < busy_until);
        check("stall_f", 32'(StallF), 32'(s));
        check("stall_d", 32'(StallD), 32'(s));
        check("flush_e", 32'(FlushE), 32'(s));
        check("fwd_ad", 32'(ForwardAD), 32'(RegWriteM && hit(RsD, WriteRegM)));
        check("fwd_bd", 32'(ForwardBD), 32'(RegWriteM && hit(RtD, WriteRegM)));
        check("fwd_ae", 32'(ForwardAE), 32'(fwd_e(RsE)));
        check("fwd_be", 32'(ForwardBE), 32'(fwd_e(RtE)));
        check("md_busy", 32'(MdBusy), 32'(busy));
        check("md_busy_s", 32'(MdBusy_s), 32'(busy));
        check("md_err", 32'(MdErr), 32'(err));
        e16 = exp_q.pop_front();
        e4  = exp_q.pop_front();
        check("stall_cnt16", 32'(StallCount), e16);
        check("stall_cnt4", 32'(StallCount_s), e4);
    endtask

    // Advance the model across the coming rising edge, then the DUT.
    task automatic advance();
        bit s, busy;
        s    = model_stall();
        busy = (cyc < busy_until);
        if (rst) begin
            busy_until = 0; err = 0; cnt16 = 0; cnt4 = 0;
        end else begin
            if (MdStartE) begin
                if (busy) err = 1;
                else busy_until = cyc + 1 + LAT;
            end
            if (s) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
        end
        cyc++;
        exp_q.push_back(32'(cnt16));
        exp_q.push_back(32'(cnt4));
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        check_now();
        advance();
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        rst = 0;
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; JrD = 0; MdStartD = 0; MdUseD = 0; MdStartE = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    function automatic logic [AW-1:0] rand_reg();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, 3));
    endfunction

    task automatic drive_random();
        rst       = ($urandom_range(0, 49) == 0);
        RsD       = rand_reg(); RtD = rand_reg();
        RsE       = rand_reg(); RtE = rand_reg();
        WriteRegE = rand_reg(); WriteRegM = rand_reg(); WriteRegW = rand_reg();
        RegWriteE = 1'($urandom_range(0, 1));
        RegWriteM = 1'($urandom_range(0, 1));
        RegWriteW = 1'($urandom_range(0, 1));
        MemtoRegE = 1'($urandom_range(0, 1));
        MemtoRegM = 1'($urandom_range(0, 1));
        BranchD   = 1'($urandom_range(0, 1));
        JrD       = ($urandom_range(0, 3) == 0);
        MdStartD  = ($urandom_range(0, 3) == 0);
        MdUseD    = ($urandom_range(0, 3) == 0);
        MdStartE  = ($urandom_range(0, 4) == 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Bring the DUT out of an unknown state before the model takes over.
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();

        // Reset state.
        @(negedge clk);
        check("rst_busy", 32'(MdBusy), 32'd0);
        check("rst_err", 32'(MdErr), 32'd0);
        check("rst_cnt", 32'(StallCount), 32'd0);
        @(posedge clk); #1;
        exp_q.delete();
        exp_q.push_back(32'(cnt16));
        exp_q.push_back(32'(cnt4));
        cyc++;

        // Forward priority M over W, then W alone, then register 0.
        RsE = 8; WriteRegM = 8; WriteRegW = 8; RegWriteM = 1; RegWriteW = 1;
        check_now(); check("fwd_prio_m", 32'(ForwardAE), 32'd2); advance();
        RegWriteM = 0;
        check_now(); check("fwd_prio_w", 32'(ForwardAE), 32'd1); advance();
        RsE = 0;
        check_now(); check("fwd_r0", 32'(ForwardAE), 32'd0); advance();
        clear_inputs();
        check_now(); check("idle_stall", 32'(StallD), 32'd0); advance();

        // Load-use stall and one counter step.
        MemtoRegE = 1; RtE = 5; RtD = 5;
        check_now(); check("lw_stall", 32'(StallF && StallD && FlushE), 32'd1); advance();
        clear_inputs();
        check_now(); check("lw_cnt", 32'(StallCount), 32'd1); advance();

        // Branch operand produced in E stalls; once in M it forwards.
        BranchD = 1; RtD = 9; RegWriteE = 1; WriteRegE = 9;
        check_now(); check("br_stall", 32'(StallD), 32'd1); advance();
        WriteRegE = 3; RegWriteM = 1; WriteRegM = 9; MemtoRegM = 0;
        check_now();
        check("br_nostall", 32'(StallD), 32'd0);
        check("br_fwd_bd", 32'(ForwardBD), 32'd1);
        advance();
        clear_inputs();

        // Mult/div busy window with a dependent mfhi/mflo held in Decode.
        MdStartE = 1; MdUseD = 1;
        check_now(); check("md_pulse_stall", 32'(StallD), 32'd1); advance();
        MdStartE = 0;
        for (int i = 0; i < LAT; i++) begin
            check_now();
            check("md_win_busy", 32'(MdBusy), 32'd1);
            check("md_win_stall", 32'(StallD), 32'd1);
            advance();
        end
        check_now();
        check("md_done_busy", 32'(MdBusy), 32'd0);
        check("md_done_stall", 32'(StallD), 32'd0);
        advance();
        clear_inputs();

        // Second start while two cycles remain: ignored, flags the error.
        MdStartE = 1; cycle();
        MdStartE = 0; cycle(); cycle();
        MdStartE = 1; cycle();
        MdStartE = 0;
        check_now(); check("viol_err", 32'(MdErr), 32'd1); check("viol_busy", 32'(MdBusy), 32'd1); advance();
        check_now(); check("viol_idle", 32'(MdBusy), 32'd0); advance();
        check_now(); check("viol_sticky", 32'(MdErr), 32'd1); advance();

        // Reset mid-count with a start pending in the same cycle.
        MdStartE = 1; cycle();
        cycle();
        rst = 1;
        check_now(); advance();
        rst = 0; MdStartE = 0;
        check_now();
        check("rst_mid_busy", 32'(MdBusy), 32'd0);
        check("rst_mid_err", 32'(MdErr), 32'd0);
        check("rst_mid_cnt", 32'(StallCount), 32'd0);
        advance();

        // Hold a load-use stall for 20 cycles: narrow counter pins at 15.
        do_reset();
        MemtoRegE = 1; RtE = 5; RtD = 5;
        repeat (20) cycle();
        clear_inputs();
        check_now();
        check("sat_cnt4", 32'(StallCount_s), 32'd15);
        check("sat_cnt16", 32'(StallCount), 32'd20);
        advance();
        check_now(); check("sat_hold", 32'(StallCount_s), 32'd15); advance();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            drive_random();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 Parameter RF_ADDR_WIDTH, default 5: register-file address width.
REQ-002 Parameter MD_LATENCY, default 4, range 2..15: number of cycles the multiply/divide unit takes to produce HI/LO.
REQ-003 Parameter PERF_WIDTH, default 16: width of the stall performance counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 RsD, RtD, RsE, RtE  input  RF_ADDR_WIDTH each  source register fields in Decode and Execute.
REQ-007 WriteRegE, WriteRegM, WriteRegW  input  RF_ADDR_WIDTH each  destination registers.
REQ-008 RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM  input  1 each  pipeline control.
REQ-009 BranchD, JrD  input  1 each  branch or jump-register instruction in Decode.
REQ-010 MdStartD, MdUseD  input  1 each  Decode holds a mult/div, or an mfhi/mflo.
REQ-011 MdStartE  input  1  mult/div instruction in Execute that has not been flushed.
REQ-012 StallF, StallD, FlushE  output  1 each  pipeline stall and flush.
REQ-013 ForwardAD, ForwardBD  output  1 each  Decode comparator forward from ALUOutM.
REQ-014 ForwardAE, ForwardBE  output  2 each  ALU source select: 0 = RF, 1 = ResultW, 2 = ALUOutM.
REQ-015 MdBusy  output  1  multiply/divide unit is busy.
REQ-016 MdErr  output  1  sticky flag for a protocol violation.
REQ-017 StallCount  output  PERF_WIDTH  number of stalled cycles.

Function
REQ-018 Register 0 never matches in any hazard or forward comparison.
REQ-019 ForwardAE is 2 when RegWriteM and RsE == WriteRegM; otherwise 1 when RegWriteW and RsE == WriteRegW; otherwise 0. M has priority when both match.
REQ-020 ForwardBE follows the same rule as ForwardAE, using RtE.
REQ-021 ForwardAD = RegWriteM and RsD == WriteRegM. ForwardBD = RegWriteM and RtD == WriteRegM. Each uses its own source field.
REQ-022 lwstall = MemtoRegE and (RsD == RtE or RtD == RtE).
REQ-023 branchstall = BranchD and ((RegWriteE and RsD or RtD == WriteRegE) or (MemtoRegM and RsD or RtD == WriteRegM)).
REQ-024 jrstall is the same as branchstall, but uses JrD and RsD only.
REQ-025 mdstall = (MdStartD or MdUseD) and (MdBusy or MdStartE).
REQ-026 StallF = StallD = FlushE = lwstall or branchstall or jrstall or mdstall. These outputs are combinational in the same cycle.
REQ-027 md_cnt is 4 bits. MdBusy = (md_cnt != 0).
REQ-028 When MdStartE = 1 and md_cnt == 0, md_cnt loads MD_LATENCY on the next edge.
REQ-029 Otherwise, when md_cnt != 0, md_cnt decrements by 1 each cycle. MdBusy is therefore high for exactly MD_LATENCY cycles after the start edge.
REQ-030 MdStartE = 1 while md_cnt != 0 is a violation:
- the start is ignored, and md_cnt keeps decrementing;
- MdErr sets on the next edge and stays set until reset.
REQ-031 StallCount increments by 1 on each edge where StallD = 1.
REQ-032 StallCount saturates at all-ones and does not wrap.
REQ-033 When no hazard condition is active, all stall and flush outputs are 0 and all forward selects are 0.

Reset
REQ-034 When rst = 1 at an edge, the next state is md_cnt = 0, MdBusy = 0, MdErr = 0 and StallCount = 0. This holds even when a mult/div is in progress or MdStartE = 1 in the same cycle.
REQ-035 The combinational outputs do not depend on rst. Only MdBusy and mdstall change as a result of reset.

Verification
REQ-036 Forward priority: RsE = 8, WriteRegM = WriteRegW = 8, RegWriteM = RegWriteW = 1 -> ForwardAE = 2. Then RegWriteM = 0 -> ForwardAE = 1. Then RsE = 0 -> ForwardAE = 0.
REQ-037 Load-use stall: MemtoRegE = 1, RtE = 5, RtD = 5 -> StallF = StallD = FlushE = 1, and StallCount increments by 1 on the next edge.
REQ-038 Branch forward and stall:
- BranchD = 1, RtD = 9, RegWriteE = 1, WriteRegE = 9 -> StallD = 1.
- Next, RegWriteM = 1, WriteRegM = 9, MemtoRegM = 0, and E no longer matches -> StallD = 0 and ForwardBD = 1.
REQ-039 Mult/div busy, with MD_LATENCY = 4:
- MdStartE pulse -> MdBusy = 1 for exactly 4 cycles.
- MdUseD held high -> StallD = 1 in the pulse cycle and for those 4 cycles, then 0.
REQ-040 Violation and reset:
- A second MdStartE while md_cnt = 2 -> MdErr = 1 on the next edge, and md_cnt continues down to 0.
- rst = 1 mid-count -> md_cnt = 0, MdErr = 0, StallCount = 0 after one edge.
REQ-041 StallCount saturation: with PERF_WIDTH = 4, hold lwstall for 20 cycles -> StallCount = 15 and stays at 15.
